monopix2_ro_emulator: RTL and testbench
=======================================

# monopix2_ro_emulator

Cycle-accurate emulator of the LF-Monopix2 end-of-column readout, seen from the chip side of the readout interface. It buffers injected hit words, raises TokOut, honours the DAQ's Freeze/Read sequence, and serialises each hit MSB-first on DataOut. It runs in the readout clock domain, so the readout path can be exercised in simulation and on-FPGA loopback without a sensor attached.

## Interface
- Parameters:
  - DEPTH, 64, hit buffer depth in words; power of two, ≥ 4.
  - HIT_WIDTH, 27, serial word length: col[26:21], row[20:12], te[11:6], le[5:0].
- Ports:
  - ClkOut, in, 1, readout clock; all logic on its rising edge.
  - nRst, in, 1, asynchronous active-low reset.
  - HIT_DATA, in, HIT_WIDTH, hit word to enqueue.
  - HIT_VALID, in, 1, push request.
  - HIT_READY, out, 1, buffer not full; a push happens when HIT_VALID & HIT_READY.
  - Freeze, in, 1, DAQ freeze request.
  - Read, in, 1, DAQ read strobe, sampled level.
  - TokOut, out, 1, token: hits available for readout.
  - DataOut, out, 1, serial hit data.
  - HIT_COUNT, out, $clog2(DEPTH)+1, current buffer occupancy.
  - READ_ERR, out, 1, sticky protocol-violation flag.

## Operation
- State machine in `monopix2_ro_emulator`: IDLE, FROZEN, SHIFT, DRAIN.
- IDLE:
  - TokOut = (occupancy ≠ 0), registered.
  - Freeze=1 → FROZEN; frozen_cnt <= occupancy at that edge, including a push on the same edge.
- FROZEN:
  - Read=1 with frozen_cnt ≠ 0 → pop the FIFO head into a HIT_WIDTH shift register, frozen_cnt--, bit_cnt <= HIT_WIDTH-1, go to SHIFT.
  - Read=1 with frozen_cnt = 0 → READ_ERR <= 1; no pop.
  - Freeze=0 → IDLE. Unread frozen hits stay in the buffer and are re-frozen on the next Freeze.
- SHIFT:
  - DataOut = shreg[MSB]; shift left one bit per cycle; bit_cnt-- each cycle.
  - After bit 0 is driven: Freeze=1 → FROZEN; Freeze=0 → DRAIN.
  - Read=1 during SHIFT → READ_ERR <= 1, strobe ignored.
- DRAIN: one cycle with DataOut=0, then IDLE. Guarantees the receiver a gap before TokOut may re-rise.
- While frozen, TokOut = (frozen_cnt ≠ 0). Hits pushed while frozen are never counted into the current frame.
- Pushes are accepted in every state. A simultaneous push and pop leaves occupancy unchanged.
- Full buffer: HIT_READY=0, no word lost (handshake). Pop from empty cannot occur because frozen_cnt ≤ occupancy.
- READ_ERR clears only on reset.

## Timing
- Reset values: TokOut=0, DataOut=0, HIT_READY=1, HIT_COUNT=0, READ_ERR=0, state=IDLE, frozen_cnt=0.
- Reset asserted mid-operation clears the buffer and aborts the current word: DataOut=0 asynchronously.
- Push → TokOut: a push at edge N makes TokOut high after edge N+1 (occupancy register, then token register).
- Read → data: Read sampled high at edge N puts the word MSB on DataOut after edge N+1; the LSB appears after edge N+HIT_WIDTH.
- The last bit is held for one cycle; the earliest next Read is sampled at edge N+HIT_WIDTH+1.
- TokOut falls after the edge that pops the last frozen hit, while that word is still shifting.
- Freeze falling during SHIFT does not truncate the word.
- Occupancy and frozen_cnt are unsigned, width $clog2(DEPTH)+1. No wrap: occupancy saturates at DEPTH by backpressure. FIFO pointers wrap modulo DEPTH.

## Structure
- Package `monopix2_emu_pkg`: state enum, HIT_WIDTH, and field offsets/widths (COL_W=6, ROW_W=9, TE_W=6, LE_W=6).
- Sub-module `hit_fifo`:
  - Synchronous single-clock FIFO, first-word-fall-through.
  - Ports: push/pop/full/empty/count; async active-low reset.
- Top level holds the FSM, frozen_cnt, bit_cnt, shift register and error flag. Target is about 200 lines of RTL in total.

## Test plan
- Single hit: push 27'h5A5_A5A5. Freeze, then Read one cycle → TokOut rises 2 cycles after the push. DataOut carries 101101001011010010110100101 MSB-first starting 1 cycle after Read. TokOut falls the cycle after the pop.
- Frame isolation: push 3 hits, Freeze, push 2 more, read until TokOut=0 → exactly 3 words out. Release Freeze, re-Freeze → TokOut=1, remaining 2 words read in push order.
- Backpressure: DEPTH=64; push 70 with VALID held → HIT_READY=0 after 64 pushes, HIT_COUNT=64. Pop one → one further push accepted, no loss.
- Protocol errors: Read pulse mid-SHIFT → READ_ERR=1, word unaffected. Read with frozen_cnt=0 → READ_ERR=1, DataOut stays 0.
- Freeze release mid-word: drop Freeze at bit 10 → all 27 bits are emitted, one DRAIN cycle follows, then IDLE with TokOut reflecting remaining occupancy.
- Async reset: assert nRst at bit 5 of a word → DataOut=0, TokOut=0 and HIT_COUNT=0 immediately. After release, HIT_READY=1 and the first push behaves as in the single-hit test.

Source files
------------

// File: rtl/monopix2_emu_pkg.sv
// Shared definitions for the LF-Monopix2 end-of-column readout emulator.
//   ro_state_e : readout FSM states
//   HitWidth   : serial hit word length
//   *W / *Lsb  : hit word field widths and bit offsets (col, row, te, le; MSB to LSB)
package monopix2_emu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFrozen,
    StShift,
    StDrain
  } ro_state_e;

  localparam int unsigned HitWidth = 27;

  localparam int unsigned ColW = 6;
  localparam int unsigned RowW = 9;
  localparam int unsigned TeW  = 6;
  localparam int unsigned LeW  = 6;

  localparam int unsigned LeLsb  = 0;
  localparam int unsigned TeLsb  = LeLsb + LeW;
  localparam int unsigned RowLsb = TeLsb + TeW;
  localparam int unsigned ColLsb = RowLsb + RowW;

endpackage

// File: rtl/hit_fifo.sv
// Single-clock first-word-fall-through hit buffer.
// Ports:
//   clk_i, rst_ni     : clock, asynchronous active-low reset (empties the buffer)
//   push_i, wdata_i   : enqueue request and word; ignored while full
//   pop_i             : dequeue the head word; ignored while empty
//   rdata_o           : current head word (valid whenever not empty)
//   full_o, empty_o   : occupancy flags
//   count_o           : occupancy, 0..Depth
module hit_fifo #(
  parameter int unsigned Depth = 64,
  parameter int unsigned Width = 27
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Pointers wrap naturally because Depth is a power of two.
  always_comb begin
    wptr_d  = wptr_q + PtrW'(push_ok);
    rptr_d  = rptr_q + PtrW'(pop_ok);
    count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever observed.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/monopix2_ro_emulator.sv
// Chip-side emulator of the LF-Monopix2 end-of-column readout.
// Buffers injected hits, raises TokOut, follows the DAQ Freeze/Read handshake and
// serialises each hit MSB-first on DataOut.
// Ports:
//   ClkOut, nRst         : readout clock, asynchronous active-low reset
//   HIT_DATA, HIT_VALID  : hit injection; accepted when HIT_VALID & HIT_READY
//   HIT_READY            : buffer not full
//   Freeze, Read         : DAQ freeze request and read strobe (sampled levels)
//   TokOut               : hits available (occupancy in idle, frame count while frozen)
//   DataOut              : serial hit data
//   HIT_COUNT            : buffer occupancy
//   READ_ERR             : sticky protocol-violation flag, cleared only by reset
module monopix2_ro_emulator
  import monopix2_emu_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned HIT_WIDTH = HitWidth
) (
  input  logic                   ClkOut,
  input  logic                   nRst,
  input  logic [HIT_WIDTH-1:0]   HIT_DATA,
  input  logic                   HIT_VALID,
  output logic                   HIT_READY,
  input  logic                   Freeze,
  input  logic                   Read,
  output logic                   TokOut,
  output logic                   DataOut,
  output logic [$clog2(DEPTH):0] HIT_COUNT,
  output logic                   READ_ERR
);

  localparam int unsigned CntW    = $clog2(DEPTH) + 1;
  localparam int unsigned BitCntW = $clog2(HIT_WIDTH);

  ro_state_e              state_q, state_d;
  logic [CntW-1:0]        frozen_cnt_q, frozen_cnt_d;
  logic [BitCntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [HIT_WIDTH-1:0]   shreg_q, shreg_d;
  logic                   dout_q, dout_d;
  logic                   tok_q, tok_d;
  logic                   err_q, err_d;

  logic                   push, pop;
  logic                   fifo_full, fifo_empty;
  logic [HIT_WIDTH-1:0]   fifo_head;
  logic [CntW-1:0]        occupancy;

  assign push      = HIT_VALID & ~fifo_full;
  assign HIT_READY = ~fifo_full;
  assign HIT_COUNT = occupancy;
  assign TokOut    = tok_q;
  assign DataOut   = dout_q;
  assign READ_ERR  = err_q;

  hit_fifo #(
    .Depth (DEPTH),
    .Width (HIT_WIDTH)
  ) u_hit_fifo (
    .clk_i   (ClkOut),
    .rst_ni  (nRst),
    .push_i  (push),
    .wdata_i (HIT_DATA),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (occupancy)
  );

  always_comb begin
    state_d      = state_q;
    frozen_cnt_d = frozen_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    dout_d       = 1'b0;
    err_d        = err_q;
    pop          = 1'b0;
    tok_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (Freeze) begin
          state_d      = StFrozen;
          // A push on the freezing edge belongs to this frame.
          frozen_cnt_d = occupancy + CntW'(push);
        end
      end

      StFrozen: begin
        if (!Freeze) begin
          state_d = StIdle;
        end else if (Read) begin
          if ((frozen_cnt_q != '0) && !fifo_empty) begin
            pop          = 1'b1;
            shreg_d      = fifo_head;
            frozen_cnt_d = frozen_cnt_q - 1'b1;
            bit_cnt_d    = BitCntW'(HIT_WIDTH - 1);
            state_d      = StShift;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      StShift: begin
        // DataOut is registered, so the MSB leaves one edge after the pop.
        dout_d  = shreg_q[HIT_WIDTH-1];
        shreg_d = shreg_q << 1;
        if (Read) begin
          err_d = 1'b1;
        end
        if (bit_cnt_q == '0) begin
          state_d = Freeze ? StFrozen : StDrain;
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end

      StDrain: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Token follows the state being entered: occupancy when idle, frame count when
    // frozen, and forced low across the drain gap.
    unique case (state_d)
      StIdle:            tok_d = (occupancy != '0);
      StFrozen, StShift: tok_d = (frozen_cnt_d != '0);
      StDrain:           tok_d = 1'b0;
      default:           tok_d = 1'b0;
    endcase
  end

  always_ff @(posedge ClkOut or negedge nRst) begin
    if (!nRst) begin
      state_q      <= StIdle;
      frozen_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      dout_q       <= 1'b0;
      tok_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      frozen_cnt_q <= frozen_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      dout_q       <= dout_d;
      tok_q        <= tok_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_monopix2_ro_emulator.sv
// Self-checking bench for monopix2_ro_emulator: directed phases plus a random soak,
// all checked every cycle against a queue-based readout model.
module tb_monopix2_ro_emulator;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned HW    = 27;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  localparam logic [HW-1:0] SingleHit  = 27'h5A5A5A5;
  localparam logic [HW-1:0] SingleBits = 27'b101101001011010010110100101;

  logic          ClkOut    = 1'b0;
  logic          nRst      = 1'b0;
  logic [HW-1:0] HIT_DATA  = '0;
  logic          HIT_VALID = 1'b0;
  logic          Freeze    = 1'b0;
  logic          Read      = 1'b0;
  logic          HIT_READY;
  logic          TokOut;
  logic          DataOut;
  logic [CW-1:0] HIT_COUNT;
  logic          READ_ERR;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model: buffered words, pending serial bits, frame bookkeeping.
  logic [HW-1:0] mq[$];
  bit            mpipe[$];
  bit            m_frozen, m_gap, m_dout, m_tok, m_err;
  int            m_frame;

  always #5 ClkOut = ~ClkOut;

  monopix2_ro_emulator #(
    .DEPTH     (DEPTH),
    .HIT_WIDTH (HW)
  ) dut (
    .ClkOut    (ClkOut),
    .nRst      (nRst),
    .HIT_DATA  (HIT_DATA),
    .HIT_VALID (HIT_VALID),
    .HIT_READY (HIT_READY),
    .Freeze    (Freeze),
    .Read      (Read),
    .TokOut    (TokOut),
    .DataOut   (DataOut),
    .HIT_COUNT (HIT_COUNT),
    .READ_ERR  (READ_ERR)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpipe.delete();
    m_frozen = 1'b0;
    m_gap    = 1'b0;
    m_dout   = 1'b0;
    m_tok    = 1'b0;
    m_err    = 1'b0;
    m_frame  = 0;
  endtask

  // One clock edge of protocol behaviour, given the inputs sampled at that edge.
  task automatic model_step(input bit v, input logic [HW-1:0] d, input bit f, input bit r);
    int            occ;
    bit            push;
    logic [HW-1:0] w;
    occ    = mq.size();
    push   = v && (occ < DEPTH);
    m_dout = 1'b0;
    if (mpipe.size() != 0) begin
      m_dout = mpipe.pop_front();
      if (r) m_err = 1'b1;
      if (mpipe.size() == 0 && !f) begin
        m_frozen = 1'b0;
        m_gap    = 1'b1;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (!m_frozen) begin
      if (f) begin
        m_frozen = 1'b1;
        m_frame  = occ + int'(push);
      end
    end else if (!f) begin
      m_frozen = 1'b0;
    end else if (r) begin
      if (m_frame > 0) begin
        w = mq.pop_front();
        m_frame--;
        for (int b = HW - 1; b >= 0; b--) mpipe.push_back(w[b]);
      end else begin
        m_err = 1'b1;
      end
    end
    if (push) mq.push_back(d);
    if (m_gap)         m_tok = 1'b0;
    else if (m_frozen) m_tok = (m_frame != 0);
    else               m_tok = (occ != 0);
  endtask

  // Compare process: every cycle, half a period after the active edge.
  always @(negedge ClkOut) begin
    if (chk_en) begin
      chk("DataOut", DataOut, m_dout);
      chk("TokOut", TokOut, m_tok);
      chk("HIT_COUNT", HIT_COUNT, mq.size());
      chk("HIT_READY", HIT_READY, mq.size() < DEPTH);
      chk("READ_ERR", READ_ERR, m_err);
    end
  end

  task automatic cyc(input bit v, input logic [HW-1:0] d, input bit f, input bit r);
    HIT_VALID = v;
    HIT_DATA  = d;
    Freeze    = f;
    Read      = r;
    @(posedge ClkOut);
    model_step(v, d, f, r);
    @(negedge ClkOut);
  endtask

  task automatic idle(input int n, input bit f);
    repeat (n) cyc(1'b0, '0, f, 1'b0);
  endtask

  // Read pulse, then capture the 27 serial bits MSB first. Freeze is dropped from
  // bit rel_at onward; an extra Read is pulsed at bit err_at.
  task automatic read_word(output logic [HW-1:0] w, input int err_at, input int rel_at);
    w = '0;
    cyc(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < HW; i++) begin
      cyc(1'b0, '0, i < rel_at, i == err_at);
      w = {w[HW-2:0], DataOut};
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [HW-1:0] w;
    logic [HW-1:0] h[5];
    logic [HW-1:0] extra;
    int            acc;
    bit            frz;

    model_reset();
    repeat (3) @(negedge ClkOut);
    chk("rst_TokOut", TokOut, 1'b0);
    chk("rst_DataOut", DataOut, 1'b0);
    chk("rst_HIT_READY", HIT_READY, 1'b1);
    chk("rst_HIT_COUNT", HIT_COUNT, 0);
    chk("rst_READ_ERR", READ_ERR, 1'b0);
    nRst   = 1'b1;
    chk_en = 1'b1;

    // Single hit
    cyc(1'b1, SingleHit, 1'b0, 1'b0);
    chk("single_tok_n", TokOut, 1'b0);
    idle(1, 1'b0);
    chk("single_tok_rise", TokOut, 1'b1);
    idle(1, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b1);
    chk("single_tok_fall", TokOut, 1'b0);
    chk("single_dout_gap", DataOut, 1'b0);
    w = '0;
    for (int i = 0; i < HW; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      w = {w[HW-2:0], DataOut};
    end
    chk("single_bits", w, SingleBits);
    idle(2, 1'b0);

    // Frame isolation
    for (int k = 0; k < 3; k++) begin
      h[k] = HW'($urandom);
      cyc(1'b1, h[k], 1'b0, 1'b0);
    end
    idle(1, 1'b1);
    for (int k = 3; k < 5; k++) begin
      h[k] = HW'($urandom);
      cyc(1'b1, h[k], 1'b1, 1'b0);
    end
    acc = 0;
    for (int k = 0; k < 5 && TokOut; k++) begin
      read_word(w, -1, HW);
      chk("frame_word", w, h[acc]);
      acc++;
    end
    chk("frame_words", acc, 3);
    idle(2, 1'b0);
    idle(1, 1'b1);
    chk("refreeze_tok", TokOut, 1'b1);
    read_word(w, -1, HW);
    chk("refreeze_w3", w, h[3]);
    read_word(w, -1, HW);
    chk("refreeze_w4", w, h[4]);
    chk("refreeze_tok_end", TokOut, 1'b0);
    idle(2, 1'b0);

    // Backpressure
    acc = 0;
    for (int k = 0; k < 70; k++) begin
      if (HIT_READY) acc++;
      cyc(1'b1, HW'($urandom), 1'b0, 1'b0);
    end
    chk("bp_accepted", acc, DEPTH);
    chk("bp_ready", HIT_READY, 1'b0);
    chk("bp_count", HIT_COUNT, DEPTH);
    idle(1, 1'b1);
    read_word(w, -1, HW);
    extra = HW'($urandom);
    cyc(1'b1, extra, 1'b1, 1'b0);
    chk("bp_refill_count", HIT_COUNT, DEPTH);
    chk("bp_refill_ready", HIT_READY, 1'b0);
    for (int k = 0; k < DEPTH && TokOut; k++) read_word(w, -1, HW);
    chk("bp_frame_done", TokOut, 1'b0);
    chk("bp_left", HIT_COUNT, 1);
    idle(2, 1'b0);
    idle(1, 1'b1);
    read_word(w, -1, HW);
    chk("bp_extra_word", w, extra);
    idle(2, 1'b0);

    // Freeze released mid-word
    h[0] = HW'($urandom);
    h[1] = HW'($urandom);
    cyc(1'b1, h[0], 1'b0, 1'b0);
    cyc(1'b1, h[1], 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    read_word(w, -1, 10);
    chk("rel_word", w, h[0]);
    chk("rel_drain_tok", TokOut, 1'b0);
    idle(1, 1'b0);
    chk("rel_idle_tok", TokOut, 1'b1);
    chk("rel_idle_dout", DataOut, 1'b0);
    chk("rel_count", HIT_COUNT, 1);

    // Read strobe during shift
    chk("err_clear", READ_ERR, 1'b0);
    idle(1, 1'b1);
    read_word(w, 8, HW);
    chk("err_word", w, h[1]);
    chk("err_flag", READ_ERR, 1'b1);
    idle(2, 1'b0);

    // Asynchronous reset at bit 5 of an all-ones word
    cyc(1'b1, '1, 1'b0, 1'b0);
    cyc(1'b1, HW'($urandom), 1'b0, 1'b0);
    idle(1, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b1);
    repeat (5) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("pre_rst_dout", DataOut, 1'b1);
    chk_en    = 1'b0;
    HIT_VALID = 1'b0;
    Freeze    = 1'b0;
    Read      = 1'b0;
    #2 nRst = 1'b0;
    #1;
    chk("arst_dout", DataOut, 1'b0);
    chk("arst_tok", TokOut, 1'b0);
    chk("arst_count", HIT_COUNT, 0);
    chk("arst_err", READ_ERR, 1'b0);
    @(negedge ClkOut);
    model_reset();
    nRst = 1'b1;
    chk("arst_ready", HIT_READY, 1'b1);
    chk_en = 1'b1;
    cyc(1'b1, SingleHit, 1'b0, 1'b0);
    chk("arst_tok_n", TokOut, 1'b0);
    idle(1, 1'b0);
    chk("arst_tok_rise", TokOut, 1'b1);

    // Read with an empty frame
    idle(1, 1'b1);
    read_word(w, -1, HW);
    chk("arst_word", w, SingleBits);
    chk("empty_err_before", READ_ERR, 1'b0);
    chk("empty_tok", TokOut, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1);
    chk("empty_err", READ_ERR, 1'b1);
    chk("empty_dout", DataOut, 1'b0);
    idle(1, 1'b1);
    chk("empty_dout_hold", DataOut, 1'b0);
    idle(2, 1'b0);

    // Random soak
    frz = 1'b0;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 15) == 0) frz = ~frz;
      cyc($urandom_range(0, 2) != 0, HW'($urandom), frz, $urandom_range(0, 5) == 0);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
